// File: rtl/cpi_pkg.sv
// Shared types and helpers for the CPI capture back-end.
package cpi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SOF,
        CAPTURE,
        SKIP
    } cpi_cap_state_e;

    typedef struct packed {
        logic        valid;
        logic [15:0] data;
        logic        sof;
        logic        eol;
        logic        eof;
    } cpi_pix_beat_t;

    function automatic int lane_width(input int pix_w);
        return (pix_w <= 8) ? 8 : 16;
    endfunction

    function automatic int lanes_per_word(input int pix_w, input logic pack);
        return pack ? (32 / lane_width(pix_w)) : 1;
    endfunction

endpackage

// File: rtl/udma_cpi_sync_fifo.sv
// First-word-fall-through synchronous FIFO; a pop frees a slot for a same-cycle push.
module udma_cpi_sync_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] data_o,
    output logic              full_o,
    output logic              empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty_o = (wr_ptr == rd_ptr);
    assign full_o  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/udma_cpi_window_packer.sv
// CPI capture back-end: frame skipping, X/Y window crop, lane packing into 32-bit words, output FIFO.
module udma_cpi_window_packer
    import cpi_pkg::*;
#(
    parameter int PIX_W      = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cfg_en_i,
    input  logic             cfg_pack_i,
    input  logic [7:0]       cfg_skip_i,
    input  logic [CNT_W-1:0] cfg_x0_i,
    input  logic [CNT_W-1:0] cfg_x1_i,
    input  logic [CNT_W-1:0] cfg_y0_i,
    input  logic [CNT_W-1:0] cfg_y1_i,
    input  logic             pix_valid_i,
    input  logic [PIX_W-1:0] pix_data_i,
    input  logic             pix_sof_i,
    input  logic             pix_eol_i,
    input  logic             pix_eof_i,
    output logic [31:0]      data_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             frame_done_evt_o,
    output logic             overflow_evt_o,
    output logic             sync_err_evt_o
);
    localparam int LW = lane_width(PIX_W);

    cpi_cap_state_e   state_q, state_d;
    cpi_pix_beat_t    beat;
    logic [7:0]       skip_q;
    logic             pack_q;
    logic [CNT_W-1:0] x0_q, x1_q, y0_q, y1_q;
    logic [CNT_W-1:0] x_q, y_q;
    logic [1:0]       idx_q;
    logic [31:0]      word_q;

    logic             live, sof_start, capture_now;
    logic             pack_cur;
    logic [CNT_W-1:0] x0_cur, x1_cur, y0_cur, y1_cur, x_cur, y_cur;
    logic [1:0]       idx_cur, idx_nxt, last_idx;
    logic [31:0]      word_cur, word_pix, wr_data;
    logic [4:0]       shamt;
    logic             keep, last_lane, wr_en;
    logic             fifo_full, fifo_empty, fifo_pop;
    logic [31:0]      fifo_data;

    always_comb begin
        beat       = '0;
        beat.valid = pix_valid_i;
        beat.data  = 16'(pix_data_i);
        beat.sof   = pix_sof_i;
        beat.eol   = pix_eol_i;
        beat.eof   = pix_eof_i;
    end

    // A sof outside IDLE always restarts the frame, even from CAPTURE/SKIP.
    assign live        = beat.valid && cfg_en_i && (state_q != IDLE);
    assign sof_start   = live && beat.sof;
    assign capture_now = live && (sof_start ? (skip_q == 8'd0) : (state_q == CAPTURE));

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!cfg_en_i) begin
            state_d = IDLE;
        end else if (state_q == IDLE) begin
            state_d = WAIT_SOF;
        end else begin
            if (sof_start)         state_d = (skip_q == 8'd0) ? CAPTURE : SKIP;
            if (live && beat.eof)  state_d = WAIT_SOF;
        end
    end

    always_comb begin
        frame_done_evt_o = !rst_i && capture_now && beat.eof;
        sync_err_evt_o   = !rst_i && sof_start && ((state_q == CAPTURE) || (state_q == SKIP));
        overflow_evt_o   = !rst_i && wr_en && fifo_full && !fifo_pop;
    end

    // The sof pixel sees the freshly sampled config and a cleared position/lane state.
    always_comb begin
        pack_cur  = sof_start ? cfg_pack_i : pack_q;
        x0_cur    = sof_start ? cfg_x0_i   : x0_q;
        x1_cur    = sof_start ? cfg_x1_i   : x1_q;
        y0_cur    = sof_start ? cfg_y0_i   : y0_q;
        y1_cur    = sof_start ? cfg_y1_i   : y1_q;
        x_cur     = sof_start ? '0 : x_q;
        y_cur     = sof_start ? '0 : y_q;
        idx_cur   = sof_start ? '0 : idx_q;
        word_cur  = sof_start ? '0 : word_q;
        keep      = capture_now && (x_cur >= x0_cur) && (x_cur <= x1_cur)
                                && (y_cur >= y0_cur) && (y_cur <= y1_cur);
        last_idx  = 2'(lanes_per_word(PIX_W, pack_cur) - 1);
        last_lane = (idx_cur == last_idx);
        shamt     = 5'(int'(idx_cur) * LW);
        word_pix  = word_cur | (32'(beat.data) << shamt);
        wr_data   = keep ? word_pix : word_cur;
        wr_en     = capture_now && ((keep && last_lane) ||
                                    (beat.eof && (keep || (idx_cur != 2'd0))));
        if (wr_en)     idx_nxt = '0;
        else if (keep) idx_nxt = idx_cur + 2'd1;
        else           idx_nxt = idx_cur;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            skip_q <= '0;
            idx_q  <= '0;
            x_q    <= '0;
            y_q    <= '0;
        end else if (!cfg_en_i) begin
            skip_q <= '0;
            idx_q  <= '0;
        end else begin
            if (sof_start) skip_q <= (skip_q == 8'd0) ? cfg_skip_i : skip_q - 8'd1;
            if (capture_now) begin
                idx_q <= idx_nxt;
                x_q   <= beat.eol ? '0 : x_cur + 1'b1;
                y_q   <= beat.eol ? y_cur + 1'b1 : y_cur;
            end else if (sof_start) begin
                idx_q <= '0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (sof_start) begin
            pack_q <= cfg_pack_i;
            x0_q   <= cfg_x0_i;
            x1_q   <= cfg_x1_i;
            y0_q   <= cfg_y0_i;
            y1_q   <= cfg_y1_i;
        end
        if (capture_now) word_q <= wr_en ? '0 : wr_data;
    end

    assign fifo_pop = valid_o && ready_i;

    udma_cpi_sync_fifo #(
        .DATA_W (32),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (wr_en),
        .data_i  (wr_data),
        .pop_i   (fifo_pop),
        .data_o  (fifo_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign valid_o = !fifo_empty;
    assign data_o  = valid_o ? fifo_data : 32'd0;

endmodule

// File: tb/tb_udma_cpi_window_packer.sv
// Scoreboard bench for udma_cpi_window_packer with directed frames.
module tb_udma_cpi_window_packer;
    localparam int PIX_W      = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int CNT_W      = 16;

    logic             clk = 1'b0;
    logic             rst_i;
    logic             cfg_en_i, cfg_pack_i;
    logic [7:0]       cfg_skip_i;
    logic [CNT_W-1:0] cfg_x0_i, cfg_x1_i, cfg_y0_i, cfg_y1_i;
    logic             pix_valid_i, pix_sof_i, pix_eol_i, pix_eof_i;
    logic [PIX_W-1:0] pix_data_i;
    logic [31:0]      data_o;
    logic             valid_o, ready_i;
    logic             frame_done_evt_o, overflow_evt_o, sync_err_evt_o;

    int checks = 0;
    int failures = 0;
    int fd_cnt = 0, of_cnt = 0, se_cnt = 0;
    int fd0, of0, se0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    udma_cpi_window_packer #(
        .PIX_W(PIX_W), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .cfg_en_i(cfg_en_i), .cfg_pack_i(cfg_pack_i), .cfg_skip_i(cfg_skip_i),
        .cfg_x0_i(cfg_x0_i), .cfg_x1_i(cfg_x1_i), .cfg_y0_i(cfg_y0_i), .cfg_y1_i(cfg_y1_i),
        .pix_valid_i(pix_valid_i), .pix_data_i(pix_data_i), .pix_sof_i(pix_sof_i),
        .pix_eol_i(pix_eol_i), .pix_eof_i(pix_eof_i),
        .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
        .frame_done_evt_o(frame_done_evt_o), .overflow_evt_o(overflow_evt_o),
        .sync_err_evt_o(sync_err_evt_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: event counting and word comparison, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_i) begin
            if (frame_done_evt_o) fd_cnt++;
            if (overflow_evt_o)   of_cnt++;
            if (sync_err_evt_o)   se_cnt++;
            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word: got %h expected none", data_o);
                end else begin
                    chk("word", data_o, exp_q.pop_front());
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pix(input logic [7:0] d, input logic sof, input logic eol, input logic eof);
        pix_valid_i = 1'b1;
        pix_data_i  = d;
        pix_sof_i   = sof;
        pix_eol_i   = eol;
        pix_eof_i   = eof;
        step(1);
        pix_valid_i = 1'b0;
        pix_sof_i   = 1'b0;
        pix_eol_i   = 1'b0;
        pix_eof_i   = 1'b0;
    endtask

    task automatic mark();
        fd0 = fd_cnt;
        of0 = of_cnt;
        se0 = se_cnt;
    endtask

    task automatic drain(input string name);
        ready_i = 1'b1;
        for (int i = 0; i < 60 && (exp_q.size() != 0 || valid_o); i++) step(1);
        chk({name, "_pending"}, exp_q.size(), 0);
        chk({name, "_valid_low"}, {31'd0, valid_o}, 0);
    endtask

    task automatic set_win(input int x0, input int x1, input int y0, input int y1);
        cfg_x0_i = CNT_W'(x0);
        cfg_x1_i = CNT_W'(x1);
        cfg_y0_i = CNT_W'(y0);
        cfg_y1_i = CNT_W'(y1);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        rst_i = 1'b1; cfg_en_i = 1'b1; cfg_pack_i = 1'b1; cfg_skip_i = 8'd0;
        set_win(0, 7, 0, 1);
        pix_valid_i = 1'b0; pix_data_i = '0; pix_sof_i = 1'b0; pix_eol_i = 1'b0; pix_eof_i = 1'b0;
        ready_i = 1'b1;
        step(3);
        chk("reset_valid", {31'd0, valid_o}, 0);
        chk("reset_data", data_o, 0);
        chk("reset_events", {29'd0, frame_done_evt_o, overflow_evt_o, sync_err_evt_o}, 0);
        rst_i = 1'b0;
        step(2);

        // 8x2 frame, full window, 4 pixels per word
        mark();
        exp_q.push_back(32'h03020100); exp_q.push_back(32'h07060504);
        exp_q.push_back(32'h0B0A0908); exp_q.push_back(32'h0F0E0D0C);
        for (int y = 0; y < 2; y++)
            for (int x = 0; x < 8; x++)
                pix(8'(y * 8 + x), (x == 0 && y == 0), (x == 7), (x == 7 && y == 1));
        chk("t1_frame_done", fd_cnt - fd0, 1);
        drain("t1");

        // partial word flushed at eof, 1-cycle write-to-valid latency
        mark();
        set_win(0, 15, 0, 0);
        exp_q.push_back(32'hA4A3A2A1); exp_q.push_back(32'h000000A5);
        pix(8'hA1, 1, 0, 0); pix(8'hA2, 0, 0, 0); pix(8'hA3, 0, 0, 0);
        chk("t2_valid_before_word", {31'd0, valid_o}, 0);
        pix(8'hA4, 0, 0, 0);
        chk("t2_valid_after_word", {31'd0, valid_o}, 1);
        pix(8'hA5, 0, 1, 1);
        chk("t2_frame_done", fd_cnt - fd0, 1);
        drain("t2");

        // skip=2 over 6 frames: frames 0 and 3 captured
        mark();
        cfg_pack_i = 1'b0; cfg_skip_i = 8'd2;
        exp_q.push_back(32'h30); exp_q.push_back(32'h31);
        exp_q.push_back(32'h36); exp_q.push_back(32'h37);
        for (int f = 0; f < 6; f++) begin
            pix(8'(8'h30 + 2 * f), 1, 0, 0);
            pix(8'(8'h31 + 2 * f), 0, 1, 1);
        end
        chk("t3_frame_done", fd_cnt - fd0, 2);
        drain("t3");
        cfg_skip_i = 8'd0; cfg_en_i = 1'b0;
        step(2);
        cfg_en_i = 1'b1;
        step(2);

        // cropped window on a 4x3 frame; first frame after re-enable is captured
        mark();
        cfg_pack_i = 1'b1;
        set_win(2, 3, 1, 1);
        exp_q.push_back(32'h00004746);
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 4; x++)
                pix(8'(8'h40 + y * 4 + x), (x == 0 && y == 0), (x == 3), (x == 3 && y == 2));
        chk("t4_frame_done", fd_cnt - fd0, 1);
        drain("t4");

        // overflow: 6 words into a 4-deep FIFO with no reads
        mark();
        ready_i = 1'b0; cfg_pack_i = 1'b0;
        set_win(0, 15, 0, 0);
        for (int i = 0; i < 4; i++) exp_q.push_back(32'(8'h51 + i));
        for (int i = 0; i < 6; i++) pix(8'(8'h51 + i), (i == 0), (i == 5), (i == 5));
        chk("t5_overflow", of_cnt - of0, 2);
        chk("t5_frame_done", fd_cnt - fd0, 1);
        chk("t5_hold_valid", {31'd0, valid_o}, 1);
        chk("t5_hold_data", data_o, 32'h51);
        step(3);
        chk("t5_hold_data_later", data_o, 32'h51);
        drain("t5");

        // full FIFO with a read and a write in the same cycle
        mark();
        ready_i = 1'b0;
        for (int i = 0; i < 5; i++) exp_q.push_back(32'(8'hC1 + i));
        for (int i = 0; i < 4; i++) pix(8'(8'hC1 + i), (i == 0), 0, 0);
        ready_i = 1'b1;
        pix(8'hC5, 0, 1, 1);
        chk("t5b_no_overflow", of_cnt - of0, 0);
        drain("t5b");

        // sof inside CAPTURE discards the partial word
        mark();
        cfg_pack_i = 1'b1;
        exp_q.push_back(32'h74737271);
        pix(8'h61, 1, 0, 0); pix(8'h62, 0, 0, 0); pix(8'h63, 0, 0, 0);
        pix(8'h71, 1, 0, 0); pix(8'h72, 0, 0, 0); pix(8'h73, 0, 0, 0); pix(8'h74, 0, 1, 1);
        chk("t6_sync_err", se_cnt - se0, 1);
        chk("t6_frame_done", fd_cnt - fd0, 1);
        drain("t6");

        // cfg_en_i dropped mid-frame: partial word lost, stray pixels ignored
        mark();
        pix(8'h81, 1, 0, 0); pix(8'h82, 0, 0, 0);
        cfg_en_i = 1'b0;
        step(2);
        cfg_en_i = 1'b1;
        step(1);
        pix(8'h83, 0, 0, 0); pix(8'h84, 0, 1, 1);
        exp_q.push_back(32'h94939291);
        pix(8'h91, 1, 0, 0); pix(8'h92, 0, 0, 0); pix(8'h93, 0, 0, 0); pix(8'h94, 0, 1, 1);
        chk("t7_frame_done", fd_cnt - fd0, 1);
        chk("t7_sync_err", se_cnt - se0, 0);
        drain("t7");

        // reset mid-frame with a word pending
        ready_i = 1'b0;
        pix(8'hE1, 1, 0, 0); pix(8'hE2, 0, 0, 0); pix(8'hE3, 0, 0, 0); pix(8'hE4, 0, 0, 0);
        chk("t8_word_pending", {31'd0, valid_o}, 1);
        rst_i = 1'b1;
        step(1);
        chk("t8_reset_valid", {31'd0, valid_o}, 0);
        chk("t8_reset_data", data_o, 0);
        rst_i = 1'b0; ready_i = 1'b1;
        step(2);
        mark();
        exp_q.push_back(32'hF4F3F2F1);
        pix(8'hF1, 1, 0, 0); pix(8'hF2, 0, 0, 0); pix(8'hF3, 0, 0, 0); pix(8'hF4, 0, 1, 1);
        chk("t8_frame_done", fd_cnt - fd0, 1);
        drain("t8");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
